// File: rtl/l1_sched_pkg.sv
// Shared defaults, requester ID type and round-robin helper for the L1 read scheduler.
package l1_sched_pkg;

  localparam int REQS_DEF       = 4;
  localparam int REQ_W_DEF      = $clog2(REQS_DEF);
  localparam int ADDR_W_DEF     = 11;
  localparam int DATA_WIDTH_DEF = 128;
  localparam int MAX_REQS       = 32;

  typedef logic [REQ_W_DEF-1:0] req_id_t;

  // Index of the first set bit of elig[n-1:0] searching upward from ptr with wrap, or -1 if none.
  function automatic int rr_first(input logic [MAX_REQS-1:0] elig, input int ptr, input int n);
    int idx;
    rr_first = -1;
    for (int i = MAX_REQS - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = (ptr + i) % n;
        if (elig[5'(idx)]) rr_first = idx;
      end
    end
  endfunction

endpackage

// File: rtl/l1_tag_fifo.sv
// In-order FIFO of requester IDs; the head names the owner of the next returning beat.
module l1_tag_fifo
  import l1_sched_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type id_t  = req_id_t
) (
  input  logic clk1x,
  input  logic reset_n,
  input  logic push_i,
  input  id_t  push_id_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output id_t  head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] wr_q, wr_d, rd_q, rd_d;
  id_t            mem_q [DEPTH];

  // The extra pointer bit separates a full ring from an empty one.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign head_o  = mem_q[rd_q[PTR_W-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i && !full_o) wr_d = wr_q + 1'b1;
    if (pop_i && !empty_o) rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk1x) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk1x) begin
    if (push_i && !full_o) mem_q[wr_q[PTR_W-1:0]] <= push_id_i;
  end

endmodule

// File: rtl/l1_read_sched.sv
// Round-robin scheduler sharing one BRAM read port among REQS requesters, with
// per-requester outstanding limits and in-order response steering via a tag FIFO.
module l1_read_sched
  import l1_sched_pkg::*;
#(
  parameter int REQS       = REQS_DEF,
  parameter int REQ_W      = $clog2(REQS),
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TAG_DEPTH  = 8,
  parameter int MAX_OUT    = 2
) (
  input  logic                   clk1x,
  input  logic                   reset_n,
  input  logic [REQS-1:0]        req_v,
  output logic [REQS-1:0]        req_r,
  input  logic [REQS*ADDR_W-1:0] req_d,
  output logic                   m_v,
  input  logic                   m_r,
  output logic [ADDR_W-1:0]      m_d,
  input  logic                   s_v,
  output logic                   s_r,
  input  logic [DATA_WIDTH-1:0]  s_d,
  output logic [REQS-1:0]        rsp_v,
  input  logic [REQS-1:0]        rsp_r,
  output logic [DATA_WIDTH-1:0]  rsp_d,
  output logic                   err
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  typedef logic [REQ_W-1:0] id_t;

  logic [CNT_W-1:0]    cnt_q [REQS];
  logic [CNT_W-1:0]    cnt_d [REQS];
  id_t                 ptr_q, ptr_d;
  logic                mv_q, mv_d;
  logic [ADDR_W-1:0]   md_q, md_d;
  logic                err_q, err_d;
  logic                fifo_full, fifo_empty, pop, accept, gnt_found;
  id_t                 head, gnt;
  logic [REQS-1:0]     elig;
  logic [MAX_REQS-1:0] elig_ext;
  int                  gnt_idx;

  assign m_v   = mv_q;
  assign m_d   = md_q;
  assign err   = err_q;
  assign rsp_d = s_d;

  // A full tag FIFO blocks everyone, even when a pop frees a slot this same cycle.
  always_comb begin
    elig = '0;
    for (int k = 0; k < REQS; k++)
      elig[k] = req_v[k] && (cnt_q[k] < CNT_W'(MAX_OUT)) && !fifo_full;
    elig_ext = '0;
    elig_ext[REQS-1:0] = elig;
    gnt_idx   = rr_first(elig_ext, int'(ptr_q), REQS);
    gnt_found = (gnt_idx >= 0);
    gnt       = REQ_W'(gnt_idx);
    accept    = reset_n && gnt_found && (!mv_q || m_r);
  end

  always_comb begin
    req_r = '0;
    rsp_v = '0;
    s_r   = 1'b0;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    mv_d  = mv_q && !m_r;
    md_d  = md_q;
    for (int k = 0; k < REQS; k++) begin
      if (head == REQ_W'(k) && !fifo_empty) begin
        rsp_v[k] = reset_n && s_v;
        s_r      = reset_n && rsp_r[k];
      end
    end
    // A beat with no tag outstanding is swallowed and flagged.
    if (fifo_empty) s_r = reset_n && s_v;
    pop   = s_v && s_r && !fifo_empty;
    err_d = err_q || (s_v && fifo_empty);
    if (accept) begin
      mv_d  = 1'b1;
      ptr_d = (gnt == REQ_W'(REQS - 1)) ? '0 : gnt + 1'b1;
    end
    for (int k = 0; k < REQS; k++) begin
      if (accept && gnt == REQ_W'(k)) begin
        req_r[k] = 1'b1;
        md_d     = req_d[k*ADDR_W +: ADDR_W];
      end
      cnt_d[k] = cnt_q[k] + CNT_W'(accept && gnt == REQ_W'(k))
                          - CNT_W'(pop && head == REQ_W'(k));
    end
  end

  always_ff @(posedge clk1x) begin
    if (!reset_n) begin
      mv_q  <= 1'b0;
      md_q  <= '0;
      ptr_q <= '0;
      err_q <= 1'b0;
      for (int k = 0; k < REQS; k++) cnt_q[k] <= '0;
    end else begin
      mv_q  <= mv_d;
      md_q  <= md_d;
      ptr_q <= ptr_d;
      err_q <= err_d;
      for (int k = 0; k < REQS; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  l1_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .id_t  (id_t)
  ) u_tag_fifo (
    .clk1x     (clk1x),
    .reset_n   (reset_n),
    .push_i    (accept),
    .push_id_i (gnt),
    .pop_i     (pop),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .head_o    (head)
  );

endmodule

// File: tb/tb_l1_read_sched.sv
// Self-checking bench for l1_read_sched: grant table with an issue/response scoreboard,
// directed multi-cycle corner cases, and a second instance for the tag-FIFO-full case.
module tb_l1_read_sched;

  localparam int REQS = 4;
  localparam int AW   = 11;
  localparam int DW   = 128;

  typedef struct packed { logic [3:0] reqV; logic [3:0] expReqR; } vec_t;
  typedef struct packed { logic [1:0] id; logic [10:0] addr; } tag_t;

  logic            clk1x = 1'b0;
  logic            reset_n;
  logic [REQS-1:0] reqV, reqR, rspV, rspR;
  logic [REQS*AW-1:0] reqD;
  logic            mV, mR, sV, sR, err;
  logic [AW-1:0]   mD;
  logic [DW-1:0]   sD, rspD;

  logic [REQS-1:0] reqVB, reqRB, rspVB, rspRB;
  logic [REQS*AW-1:0] reqDB;
  logic            mVB, mRB, sVB, sRB, errB;
  logic [AW-1:0]   mDB;
  logic [DW-1:0]   sDB, rspDB;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs [15];
  tag_t issueQ[$];
  tag_t rspQ[$];
  tag_t front, cur;
  logic doRsp, prevAcc;
  logic [10:0] base;
  int   accCount;

  always #5 clk1x = ~clk1x;

  l1_read_sched dut (
    .clk1x(clk1x), .reset_n(reset_n),
    .req_v(reqV), .req_r(reqR), .req_d(reqD),
    .m_v(mV), .m_r(mR), .m_d(mD),
    .s_v(sV), .s_r(sR), .s_d(sD),
    .rsp_v(rspV), .rsp_r(rspR), .rsp_d(rspD),
    .err(err)
  );

  l1_read_sched #(.TAG_DEPTH(8), .MAX_OUT(8)) dutFull (
    .clk1x(clk1x), .reset_n(reset_n),
    .req_v(reqVB), .req_r(reqRB), .req_d(reqDB),
    .m_v(mVB), .m_r(mRB), .m_d(mDB),
    .s_v(sVB), .s_r(sRB), .s_d(sDB),
    .rsp_v(rspVB), .rsp_r(rspRB), .rsp_d(rspDB),
    .err(errB)
  );

  function automatic logic [127:0] beatOf(input logic [1:0] id, input logic [10:0] addr);
    return {8{{3'b101, id, addr}}};
  endfunction

  function automatic logic [1:0] ohIdx(input logic [3:0] v);
    ohIdx = 2'd0;
    for (int k = 0; k < 4; k++) if (v[k]) ohIdx = 2'(k);
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk1x);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [10:0] b, input logic mr,
                               input logic sv, input logic [3:0] rr, input logic [127:0] data);
    reqV = v;
    for (int k = 0; k < REQS; k++) reqD[k*AW +: AW] = b + 11'(k);
    mR   = mr;
    sV   = sv;
    rspR = rr;
    sD   = data;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{4'b1111, 4'b0001};
    vecs[1]  = '{4'b1111, 4'b0010};
    vecs[2]  = '{4'b1111, 4'b0100};
    vecs[3]  = '{4'b1111, 4'b1000};
    vecs[4]  = '{4'b1111, 4'b0001};
    vecs[5]  = '{4'b0101, 4'b0100};
    vecs[6]  = '{4'b0101, 4'b0001};
    vecs[7]  = '{4'b0000, 4'b0000};
    vecs[8]  = '{4'b1001, 4'b1000};
    vecs[9]  = '{4'b1000, 4'b1000};
    vecs[10] = '{4'b1000, 4'b0000};
    vecs[11] = '{4'b1000, 4'b1000};
    vecs[12] = '{4'b0111, 4'b0001};
    vecs[13] = '{4'b0000, 4'b0000};
    vecs[14] = '{4'b0000, 4'b0000};

    reqVB = '0; rspRB = '1; sVB = 1'b0; sDB = '0; mRB = 1'b1;
    for (int k = 0; k < REQS; k++) reqDB[k*AW +: AW] = 11'h400 + 11'(k);

    // Reset with every input active: all outputs must stay at their reset values.
    reset_n = 1'b0;
    applyStimulus(4'b1111, 11'h0, 1'b1, 1'b1, 4'hF, '1);
    nextCycle();
    nextCycle();
    #1;
    checkOutput("reset_m_v",   128'(mV),   128'(0));
    checkOutput("reset_m_d",   128'(mD),   128'(0));
    checkOutput("reset_req_r", 128'(reqR), 128'(0));
    checkOutput("reset_s_r",   128'(sR),   128'(0));
    checkOutput("reset_rsp_v", 128'(rspV), 128'(0));
    checkOutput("reset_err",   128'(err),  128'(0));
    nextCycle();
    applyStimulus(4'b0000, 11'h0, 1'b1, 1'b0, 4'hF, '0);
    reset_n = 1'b1;

    // Grant table with immediate responses tracked by the scoreboard.
    prevAcc = 1'b0;
    for (int i = 0; i < 15; i++) begin
      nextCycle();
      base  = 11'(12'h100 + 16 * i);
      doRsp = (rspQ.size() > 0);
      if (doRsp) front = rspQ[0];
      applyStimulus(vecs[i].reqV, base, 1'b1, doRsp, 4'hF,
                    doRsp ? beatOf(front.id, front.addr) : 128'(0));
      #1;
      checkOutput("rr_req_r", 128'(reqR), 128'(vecs[i].expReqR));
      if (doRsp) begin
        checkOutput("rr_rsp_v", 128'(rspV), 128'(4'b0001 << front.id));
        checkOutput("rr_s_r",   128'(sR),   128'(1));
        checkOutput("rr_rsp_d", rspD, beatOf(front.id, front.addr));
        void'(rspQ.pop_front());
      end else begin
        checkOutput("rr_rsp_v_idle", 128'(rspV), 128'(0));
      end
      checkOutput("rr_m_v", 128'(mV), 128'(prevAcc));
      if (prevAcc) begin
        checkOutput("rr_m_d", 128'(mD), 128'(issueQ[0].addr));
        rspQ.push_back(issueQ.pop_front());
      end
      prevAcc = (vecs[i].expReqR != 4'b0000);
      if (prevAcc) begin
        cur.id   = ohIdx(vecs[i].expReqR);
        cur.addr = base + 11'(cur.id);
        issueQ.push_back(cur);
      end
    end

    // Single requester: address out next cycle, beat steered back.
    nextCycle();
    applyStimulus(4'b0001, 11'h012, 1'b1, 1'b0, 4'hF, '0);
    #1;
    checkOutput("single_req_r", 128'(reqR), 128'(4'b0001));
    nextCycle();
    applyStimulus(4'b0000, 11'h0, 1'b1, 1'b0, 4'hF, '0);
    #1;
    checkOutput("single_m_v", 128'(mV), 128'(1));
    checkOutput("single_m_d", 128'(mD), 128'(11'h012));
    nextCycle();
    applyStimulus(4'b0000, 11'h0, 1'b1, 1'b1, 4'b0001, {16{8'hA5}});
    #1;
    checkOutput("single_rsp_v", 128'(rspV), 128'(4'b0001));
    checkOutput("single_rsp_d", rspD, {16{8'hA5}});
    checkOutput("single_m_v_clear", 128'(mV), 128'(0));

    // Outstanding limit on requester 2 with responses withheld.
    accCount = 0;
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      applyStimulus(4'b0100, 11'h200, 1'b1, 1'b0, 4'hF, '0);
      #1;
      if (reqR[2]) accCount++;
    end
    checkOutput("lim_accepts", 128'(accCount), 128'(2));
    checkOutput("lim_blocked", 128'(reqR), 128'(0));
    nextCycle();
    applyStimulus(4'b0100, 11'h200, 1'b1, 1'b1, 4'hF, beatOf(2'd2, 11'h202));
    #1;
    checkOutput("lim_rsp_v", 128'(rspV), 128'(4'b0100));
    checkOutput("lim_pop_cycle_req_r", 128'(reqR), 128'(0));
    nextCycle();
    applyStimulus(4'b0100, 11'h200, 1'b1, 1'b0, 4'hF, '0);
    #1;
    checkOutput("lim_reaccept", 128'(reqR), 128'(4'b0100));
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      applyStimulus(4'b0000, 11'h0, 1'b1, 1'b1, 4'hF, beatOf(2'd2, 11'h202));
      #1;
      checkOutput("lim_drain_rsp_v", 128'(rspV), 128'(4'b0100));
    end

    // Issue backpressure: address held while m_r is low, nothing accepted.
    nextCycle();
    applyStimulus(4'b0010, 11'h300, 1'b0, 1'b0, 4'hF, '0);
    #1;
    checkOutput("bp_first_accept", 128'(reqR), 128'(4'b0010));
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      applyStimulus(4'b0010, 11'h340, 1'b0, 1'b0, 4'hF, '0);
      #1;
      checkOutput("bp_req_r_held", 128'(reqR), 128'(0));
      checkOutput("bp_m_v_held",   128'(mV),   128'(1));
      checkOutput("bp_m_d_stable", 128'(mD),   128'(11'h301));
    end
    nextCycle();
    applyStimulus(4'b0010, 11'h340, 1'b1, 1'b0, 4'hF, '0);
    #1;
    checkOutput("bp_release_accept", 128'(reqR), 128'(4'b0010));
    nextCycle();
    applyStimulus(4'b0000, 11'h0, 1'b1, 1'b0, 4'hF, '0);
    #1;
    checkOutput("bp_next_m_d", 128'(mD), 128'(11'h341));
    nextCycle();
    #1;
    checkOutput("bp_m_v_clear", 128'(mV), 128'(0));

    // Response backpressure: head owner not ready holds the beat.
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      applyStimulus(4'b0000, 11'h0, 1'b1, 1'b1, 4'b1101, beatOf(2'd1, 11'h301));
      #1;
      checkOutput("rbp_s_r_low", 128'(sR),   128'(0));
      checkOutput("rbp_rsp_v",   128'(rspV), 128'(4'b0010));
    end
    nextCycle();
    applyStimulus(4'b0000, 11'h0, 1'b1, 1'b1, 4'b0010, beatOf(2'd1, 11'h301));
    #1;
    checkOutput("rbp_s_r_high", 128'(sR), 128'(1));
    nextCycle();
    applyStimulus(4'b0000, 11'h0, 1'b1, 1'b1, 4'hF, beatOf(2'd1, 11'h341));
    #1;
    checkOutput("rbp_second_rsp_v", 128'(rspV), 128'(4'b0010));

    // Stray beat with no tag outstanding: dropped and flagged, flag sticks.
    nextCycle();
    applyStimulus(4'b0000, 11'h0, 1'b1, 1'b1, 4'hF, '1);
    #1;
    checkOutput("err_drop_s_r",   128'(sR),   128'(1));
    checkOutput("err_drop_rsp_v", 128'(rspV), 128'(0));
    nextCycle();
    applyStimulus(4'b0000, 11'h0, 1'b1, 1'b0, 4'hF, '0);
    #1;
    checkOutput("err_set", 128'(err), 128'(1));
    nextCycle();
    nextCycle();
    #1;
    checkOutput("err_sticky", 128'(err), 128'(1));

    // Reset mid-traffic: in-flight tag discarded, pointer back to requester 0.
    nextCycle();
    applyStimulus(4'b0010, 11'h500, 1'b1, 1'b0, 4'hF, '0);
    #1;
    checkOutput("rst_pre_accept", 128'(reqR), 128'(4'b0010));
    nextCycle();
    reset_n = 1'b0;
    applyStimulus(4'b1111, 11'h500, 1'b1, 1'b0, 4'hF, '0);
    #1;
    checkOutput("rst_req_r_gated", 128'(reqR), 128'(0));
    nextCycle();
    reset_n = 1'b1;
    applyStimulus(4'b1111, 11'h520, 1'b1, 1'b0, 4'hF, '0);
    #1;
    checkOutput("rst_m_v",        128'(mV),   128'(0));
    checkOutput("rst_m_d",        128'(mD),   128'(0));
    checkOutput("rst_err_clear",  128'(err),  128'(0));
    checkOutput("rst_ptr_restart", 128'(reqR), 128'(4'b0001));
    nextCycle();
    applyStimulus(4'b0000, 11'h0, 1'b1, 1'b0, 4'hF, '0);
    #1;
    checkOutput("rst_post_m_d", 128'(mD), 128'(11'h520));
    nextCycle();
    applyStimulus(4'b0000, 11'h0, 1'b1, 1'b1, 4'hF, beatOf(2'd0, 11'h520));
    #1;
    checkOutput("rst_head_is_new", 128'(rspV), 128'(4'b0001));
    nextCycle();
    applyStimulus(4'b0000, 11'h0, 1'b1, 1'b0, 4'hF, '0);

    // Tag FIFO full on the deep-limit instance: two requesters, responses withheld.
    accCount = 0;
    for (int i = 0; i < 10; i++) begin
      nextCycle();
      reqVB = 4'b0011; sVB = 1'b0;
      #1;
      if (reqRB != 4'b0000) accCount++;
    end
    checkOutput("full_accepts", 128'(accCount), 128'(8));
    checkOutput("full_blocked", 128'(reqRB),    128'(0));
    nextCycle();
    reqVB = 4'b0011; sVB = 1'b1; sDB = beatOf(2'd0, 11'h400);
    #1;
    checkOutput("full_pop_rsp_v",    128'(rspVB), 128'(4'b0001));
    checkOutput("full_pop_s_r",      128'(sRB),   128'(1));
    checkOutput("full_pop_no_accept", 128'(reqRB), 128'(0));
    nextCycle();
    sVB = 1'b0;
    #1;
    checkOutput("full_one_accept", 128'(reqRB), 128'(4'b0001));
    nextCycle();
    #1;
    checkOutput("full_again", 128'(reqRB), 128'(0));
    reqVB = 4'b0000;

    nextCycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/l1_read_sched.md
# l1_read_sched

Round-robin scheduler that shares the single read port of the L1 BRAM slice wrapper among `REQS` stream requesters. It issues one line-half read per accepted request, records the requester ID in an in-order tag FIFO, and steers each returning 16 B beat back to the requester that issued it. It limits each requester's outstanding reads so that no single stream can monopolise the wrapper's credits. It sits in the `clk1x` domain between the stream prefetch engines and the buffer read interface.

## Interface
Parameters:
- `REQS`, 4 — number of requesters
- `REQ_W`, `$clog2(REQS)` — requester ID width
- `ADDR_W`, 11 — read address width, equal to `WAYS_WIDTH+ADDR_WIDTH-1` of the BRAM wrapper
- `DATA_WIDTH`, 128 — response beat width, equal to `2*DATA_WIDTH` of the wrapper
- `TAG_DEPTH`, 8 — tag FIFO depth; must be ≥ the wrapper's credit count (6)
- `MAX_OUT`, 2 — maximum outstanding reads per requester

Ports:
- `clk1x` in 1 — single clock
- `reset_n` in 1 — synchronous, active-low reset
- `req_v` in `REQS` — per-requester read request valid
- `req_r` out `REQS` — per-requester accept
- `req_d` in `REQS*ADDR_W` — per-requester read address; requester k occupies slice [k*ADDR_W +: ADDR_W]
- `m_v` out 1 — read request valid to the wrapper `i_v`
- `m_r` in 1 — from the wrapper `i_r`
- `m_d` out `ADDR_W` — to the wrapper `i_d`
- `s_v` in 1 — from the wrapper `o_v`
- `s_r` out 1 — to the wrapper `o_r`
- `s_d` in `DATA_WIDTH` — from the wrapper `o_d`
- `rsp_v` out `REQS` — per-requester response valid, one-hot or zero
- `rsp_r` in `REQS` — per-requester response ready
- `rsp_d` out `DATA_WIDTH` — shared response data; equals `s_d`
- `err` out 1 — sticky protocol error

## Operation
- **Eligibility:** requester k is eligible when `req_v[k]` is high, `cnt[k] < MAX_OUT`, and the tag FIFO is not full.
- **Arbitration:** round-robin among eligible requesters, starting the search at pointer `ptr`. At most one grant per cycle.
- **Issue condition:** the output register is empty, or `m_r` is high.
- **Accept:** when a grant exists and the issue condition holds, `req_r[g]` = 1. Accept never depends on `m_r` alone.
- **On accept:**
  - the output register loads `req_d[g]` and `m_v` is set;
  - `g` is pushed to the tag FIFO;
  - `cnt[g]` increments;
  - `ptr` becomes `(g+1) mod REQS`.
- **No accept:** if nothing is accepted and `m_v & m_r`, `m_v` clears.
- **Response steering:** tag head `h` selects the destination.
  - `rsp_v[h]` = `s_v` & FIFO not empty.
  - `s_r` = `rsp_r[h]` & FIFO not empty.
  - On `s_v & s_r`: pop the FIFO and decrement `cnt[h]`.
- **Simultaneous events:**
  - Push and pop in the same cycle are both allowed. Occupancy is unchanged; a full FIFO is still treated as full for that cycle's eligibility.
  - Increment and decrement of the same `cnt[k]` in the same cycle leave it unchanged.
- **Error:** `s_v` high while the FIFO is empty sets `err`. `err` is cleared only by reset. That beat is dropped: `s_r` = 1 and `rsp_v` = 0.
- **Width rules:**
  - `cnt[k]` is `$clog2(MAX_OUT+1)` bits and never wraps.
  - FIFO pointers are `$clog2(TAG_DEPTH)` bits, wrapping modulo `TAG_DEPTH`, with an extra bit to distinguish full from empty.

## Timing
- **Reset values:** `m_v`=0, `m_d`=0, `req_r`=0, `s_r`=0, `rsp_v`=0, `err`=0, `ptr`=0, all `cnt`=0, FIFO empty.
- **Reset mid-operation:** in-flight tags are discarded. The wrapper is reset on the same cycle by system convention.
- **Request latency:** accept in cycle N → `m_v` high with the address in cycle N+1. `m_d` holds stable while `m_v & !m_r`.
- **Back-to-back issue:** one request per cycle is sustained when `m_r` stays high.
- **Response latency:** 0 cycles, combinational from `s_v`/`rsp_r` to `rsp_v`/`s_r`; the only path is through the FIFO head mux.
- **Per-requester order:** responses return in issue order for each requester. The tag FIFO enforces global order.

## Structure
- **Package `l1_sched_pkg`:**
  - `ADDR_W` and `DATA_WIDTH` defaults;
  - typedef `req_id_t` (`REQ_W` bits);
  - a round-robin find-first function.
- **Sub-module `l1_tag_fifo`:**
  - synchronous FIFO of `req_id_t`, depth `TAG_DEPTH`;
  - push, pop, full, empty, head;
  - same clock and reset.
- The scheduler top holds the arbiter, the output register, counters, steering and error logic.

## Test plan
- **Single requester:** requester 0 requests addr 0x012, `m_r`=1 → `m_v` with `m_d`=0x012 next cycle. `s_v` with data 0xA5.. → `rsp_v`=0001 and `rsp_d`=0xA5...
- **Fairness:** all 4 requesters request continuously, `m_r`=1, responses returned immediately → grants in order 0,1,2,3,0,… with no requester skipped.
- **Outstanding limit:** requester 2 requests with responses withheld → exactly 2 accepts, then `req_r[2]`=0. One response returned → next accept on the following cycle.
- **Backpressure:**
  - `m_r`=0 for 5 cycles → `m_d` stable, `req_r`=0.
  - `rsp_r[h]`=0 → `s_r`=0 and the beat is held until ready.
- **FIFO full:** `TAG_DEPTH`=8, `MAX_OUT`=8, responses withheld → 8 accepts, then all `req_r`=0. One pop and a request in the same cycle → exactly one accept the next cycle.
- **Error and reset:**
  - `s_v` with empty FIFO → `err`=1, sticky.
  - `reset_n`=0 mid-traffic → all outputs at reset values the next cycle; `ptr` restarts at requester 0.
